// File: rtl/count_mon_pkg.sv
// =============================================================================
// Module : count_mon_pkg
// Brief  : Shared defaults and helpers for the counter wrap monitor.
// Rev    : 1.0 - initial release
// =============================================================================
`default_nettype none

package count_mon_pkg;

    localparam int CNT_W_DEF      = 4;
    localparam int WRAP_W_DEF     = 8;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int CNT_MAX        = (1 << CNT_W_DEF) - 1;

    function automatic int fifo_ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

`default_nettype wire

// File: rtl/count_evt_fifo.sv
// =============================================================================
// Module : count_evt_fifo
// Brief  : Synchronous event FIFO; push with simultaneous pop is always accepted.
// Rev    : 1.0 - initial release
// =============================================================================
`default_nettype none

module count_evt_fifo
    import count_mon_pkg::*;
#(
    parameter int WIDTH = WRAP_W_DEF,
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             empty_o,
    output logic             drop_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int PTR_W = fifo_ptr_w(DEPTH);

    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             full_w;
    logic             do_pop_w;
    logic             do_push_w;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign full_w    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                       (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign do_pop_w  = pop_i && !empty_o;
    assign do_push_w = push_i && (!full_w || do_pop_w);
    assign drop_o    = push_i && full_w && !do_pop_w;
    assign head_o    = empty_o ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push_w) wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
        if (do_pop_w)  rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (do_push_w) mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/count_wrap_monitor.sv
// =============================================================================
// Module : count_wrap_monitor
// Brief  : Detects counter wrap-around, tallies wraps and queues wrap events.
//          Optional step checker enabled by macro COUNT_SEQ_CHECK_EN.
// Rev    : 1.0 - initial release
// =============================================================================
`default_nettype none

module count_wrap_monitor
    import count_mon_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int WRAP_W     = WRAP_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CNT_W-1:0]  count,
    input  logic              evt_ready,
    output logic              evt_valid,
    output logic [WRAP_W-1:0] evt_data,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              overflow,
    output logic              seq_err
);

    localparam logic [CNT_W-1:0] CNT_TOP = {CNT_W{1'b1}};

    logic [CNT_W-1:0]  prev_count_q;
    logic              prev_vld_q;
    logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
    logic              overflow_q, overflow_d;
    logic              wrap_w;
    logic              pop_w;
    logic              empty_w;
    logic              drop_w;

    // prev_vld_q gates the first edge after reset, which only primes prev_count_q.
    assign wrap_w = prev_vld_q && (prev_count_q == CNT_TOP) && (count == '0);
    assign pop_w  = evt_valid && evt_ready;

    always_comb begin
        wrap_cnt_d = wrap_cnt_q;
        overflow_d = overflow_q | drop_w;
        if (wrap_w) wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_count_q <= '0;
            prev_vld_q   <= 1'b0;
            wrap_cnt_q   <= '0;
            overflow_q   <= 1'b0;
        end else begin
            prev_count_q <= count;
            prev_vld_q   <= 1'b1;
            wrap_cnt_q   <= wrap_cnt_d;
            overflow_q   <= overflow_d;
        end
    end

    count_evt_fifo #(
        .WIDTH (WRAP_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (wrap_w),
        .push_data_i (wrap_cnt_d),
        .pop_i       (pop_w),
        .empty_o     (empty_w),
        .drop_o      (drop_w),
        .head_o      (evt_data)
    );

    assign evt_valid = !empty_w;
    assign wrap_cnt  = wrap_cnt_q;
    assign overflow  = overflow_q;

`ifdef COUNT_SEQ_CHECK_EN
    logic seq_err_q, seq_err_d;
    logic step_ok_w;

    // The 15->0 wrap is just the +1 step modulo 2**CNT_W.
    assign step_ok_w = (count == prev_count_q) || (count == prev_count_q + CNT_W'(1));

    always_comb begin
        seq_err_d = prev_vld_q && !step_ok_w;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) seq_err_q <= 1'b0;
        else       seq_err_q <= seq_err_d;
    end

    assign seq_err = seq_err_q;
`else
    assign seq_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_count_wrap_monitor.sv
// =============================================================================
// Module : tb_count_wrap_monitor
// Brief  : Randomized and directed bench for count_wrap_monitor with scoreboard.
// Rev    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_count_wrap_monitor;

    localparam int CW    = 4;
    localparam int WW    = 8;
    localparam int DEPTH = 4;
    localparam int CMOD  = 1 << CW;
    localparam int WMOD  = 1 << WW;
`ifdef COUNT_SEQ_CHECK_EN
    localparam bit SEQ_EN = 1'b1;
`else
    localparam bit SEQ_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [CW-1:0] count;
    logic          evt_ready;
    logic          evt_valid;
    logic [WW-1:0] evt_data;
    logic [WW-1:0] wrap_cnt;
    logic          overflow;
    logic          seq_err;

    always #5 clk = ~clk;

    count_wrap_monitor #(.CNT_W(CW), .WRAP_W(WW), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .count     (count),
        .evt_ready (evt_ready),
        .evt_valid (evt_valid),
        .evt_data  (evt_data),
        .wrap_cnt  (wrap_cnt),
        .overflow  (overflow),
        .seq_err   (seq_err)
    );

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    // Reference model: expected FIFO contents, tally and flags after the latest edge.
    int m_prev, m_tally, m_ovf, m_seq;
    bit m_pvld;
    int sb_q[$];
    int cur;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_prev  = 0;
        m_pvld  = 1'b0;
        m_tally = 0;
        m_ovf   = 0;
        m_seq   = 0;
        sb_q.delete();
    endfunction

    function automatic void model_edge(input int c, input bit rdy);
        bit wrap;
        wrap  = m_pvld && (m_prev == CMOD - 1) && (c == 0);
        m_seq = (SEQ_EN && m_pvld && c != m_prev && c != (m_prev + 1) % CMOD) ? 1 : 0;
        if (rdy && sb_q.size() > 0) void'(sb_q.pop_front());
        if (wrap) begin
            m_tally = (m_tally + 1) % WMOD;
            if (sb_q.size() < DEPTH) sb_q.push_back(m_tally);
            else                     m_ovf = 1;
        end
        m_prev = c;
        m_pvld = 1'b1;
    endfunction

    // Inputs for the next edge are driven 2 time units after the current edge.
    task automatic step(input int c, input bit rdy);
        @(posedge clk);
        #2;
        count     = CW'(c);
        evt_ready = rdy;
        cur       = c;
        model_edge(c, rdy);
    endtask

    task automatic do_reset(input int cycles);
        @(posedge clk);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("rst_evt_valid", int'(evt_valid), 0);
        check("rst_evt_data",  int'(evt_data), 0);
        check("rst_wrap_cnt",  int'(wrap_cnt), 0);
        check("rst_overflow",  int'(overflow), 0);
        check("rst_seq_err",   int'(seq_err), 0);
        repeat (cycles) @(posedge clk);
        #2;
        reset     = 1'b0;
        count     = '0;
        evt_ready = 1'b0;
        cur       = 0;
        model_edge(0, 1'b0);
    endtask

    task automatic full_wrap(input bit rdy);
        for (int c = 1; c < CMOD; c++) step(c, rdy);
        step(0, rdy);
    endtask

    // Monitor: compare DUT outputs against the scoreboard one unit after every edge.
    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            check("mon_evt_valid", int'(evt_valid), (sb_q.size() != 0) ? 1 : 0);
            if (evt_valid && sb_q.size() != 0) check("mon_evt_data", int'(evt_data), sb_q[0]);
            check("mon_wrap_cnt", int'(wrap_cnt), m_tally);
            check("mon_overflow", int'(overflow), m_ovf);
            check("mon_seq_err",  int'(seq_err), m_seq);
        end
    end

    initial begin
        int r, pct;
        reset     = 1'b1;
        count     = '0;
        evt_ready = 1'b0;
        cur       = 0;
        model_reset();
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b0;
        model_edge(0, 1'b0);
        mon_en = 1'b1;

        // Single wrap with a ready consumer
        full_wrap(1'b1);
        step(0, 1'b1);
        check("t1_wrap_cnt",  int'(wrap_cnt), 1);
        check("t1_evt_valid", int'(evt_valid), 1);
        check("t1_evt_data",  int'(evt_data), 1);
        step(0, 1'b1);
        check("t1_evt_drained", int'(evt_valid), 0);
        check("t1_overflow",    int'(overflow), 0);

        // Six wraps with a stalled consumer overflow the 4-entry FIFO
        do_reset(3);
        for (int w = 0; w < 6; w++) full_wrap(1'b0);
        step(0, 1'b0);
        check("t2_wrap_cnt", int'(wrap_cnt), 6);
        check("t2_overflow", int'(overflow), 1);
        for (int k = 1; k <= 4; k++) begin
            step(0, 1'b1);
            check("t2_drain_data", int'(evt_data), k);
        end
        step(0, 1'b1);
        check("t2_valid_low",     int'(evt_valid), 0);
        check("t2_overflow_hold", int'(overflow), 1);

        // Wrap on a full FIFO coinciding with a pop
        do_reset(2);
        for (int w = 0; w < 4; w++) full_wrap(1'b0);
        for (int c = 1; c < CMOD; c++) step(c, 1'b0);
        step(0, 1'b1);
        step(0, 1'b0);
        check("t3_head",     int'(evt_data), 2);
        check("t3_overflow", int'(overflow), 0);
        check("t3_wrap_cnt", int'(wrap_cnt), 5);

        // Long hold at max, then a non-wrap jump from max
        do_reset(2);
        for (int c = 1; c < CMOD; c++) step(c, 1'b0);
        repeat (10) step(CMOD - 1, 1'b0);
        step(0, 1'b0);
        for (int c = 1; c < CMOD; c++) step(c, 1'b0);
        step(3, 1'b0);
        step(3, 1'b0);
        check("t4_wrap_cnt", int'(wrap_cnt), 1);

        // Reset with two events pending
        do_reset(2);
        full_wrap(1'b0);
        full_wrap(1'b0);
        step(0, 1'b0);
        check("t5_pending", int'(evt_valid), 1);
        do_reset(2);
        full_wrap(1'b0);
        step(0, 1'b0);
        check("t5_first_evt", int'(evt_data), 1);

        // Step checker corner steps
        step(3, 1'b1);
        step(4, 1'b1);
        step(7, 1'b1);
        step(7, 1'b1);
        check("t6_seq_jump", int'(seq_err), SEQ_EN ? 1 : 0);
        step(8, 1'b1);
        check("t6_seq_hold", int'(seq_err), 0);
        step(9, 1'b1);
        check("t6_seq_inc",  int'(seq_err), 0);

        // Randomized walk with varying consumer throughput
        for (int blk = 0; blk < 10; blk++) begin
            pct = $urandom_range(0, 100);
            for (int i = 0; i < 150; i++) begin
                r = $urandom_range(0, 9);
                if (r < 7)       step((cur + 1) % CMOD, ($urandom_range(0, 99) < pct));
                else if (r == 7) step(cur, ($urandom_range(0, 99) < pct));
                else if (r == 8) step($urandom_range(0, CMOD - 1), ($urandom_range(0, 99) < pct));
                else             step(0, ($urandom_range(0, 99) < pct));
            end
        end

        // Tally rollover: the 256th wrap reports 0
        do_reset(2);
        for (int w = 0; w < WMOD; w++) full_wrap(1'b1);
        step(0, 1'b1);
        check("t7_wrap_roll",  int'(wrap_cnt), 0);
        check("t7_evt_valid",  int'(evt_valid), 1);
        check("t7_evt_data",   int'(evt_data), 0);
        step(0, 1'b1);
        step(0, 1'b1);

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
